// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC, single-outstanding req/ack imem port and DEPTH-entry prefetch FIFO to decode.
// Optional stall_cnt port and counter when FETCH_PERF_EN is defined.
module fetch_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH = 4,
  parameter int PC_STEP = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
`ifdef FETCH_PERF_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hlt,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_data,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
`ifdef FETCH_PERF_EN
  output logic [CNT_W-1:0]  stall_cnt,
`endif
  output logic [ADDR_W-1:0] pc
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, r_addr, w_pc_nxt, w_addr_nxt;
  logic [CW-1:0]     r_count, w_cnt_nxt;
  logic [PW-1:0]     r_wr, r_rd;
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [ADDR_W-1:0] r_ipc [DEPTH];
  logic              w_push, w_pop, w_room;

  assign imem_req   = r_state != IDLE;
  assign imem_addr  = r_addr;
  assign inst_valid = r_count != '0;
  assign inst_data  = r_data[r_rd];
  assign inst_pc    = r_ipc[r_rd];
  assign pc         = r_pc;

  // Redirect overrides both push and pop; a slot is reserved before a request is issued.
  always_comb begin
    w_pop       = inst_valid & inst_ready & ~redirect;
    w_push      = (r_state == WAIT) & imem_ack & ~redirect;
    w_cnt_nxt   = redirect ? '0 : r_count + CW'(w_push) - CW'(w_pop);
    w_room      = ~hlt & (w_cnt_nxt < CW'(DEPTH));
    w_pc_nxt    = redirect ? redirect_pc : w_push ? r_pc + ADDR_W'(PC_STEP) : r_pc;
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    case (r_state)
      IDLE: if (!redirect && w_room) begin
        w_state_nxt = WAIT;
        w_addr_nxt  = r_pc;
      end
      WAIT: if (redirect) w_state_nxt = imem_ack ? IDLE : DROP;
        else if (imem_ack) begin
          w_state_nxt = w_room ? WAIT : IDLE;
          w_addr_nxt  = w_pc_nxt;
        end
      DROP: if (imem_ack) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
      r_count <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_addr  <= w_addr_nxt;
      r_count <= w_cnt_nxt;
      if (redirect) r_rd <= r_wr;
      else if (w_pop) r_rd <= r_rd + PW'(1);
      if (w_push) r_wr <= r_wr + PW'(1);
    end

  always_ff @(posedge clk)
    if (w_push) begin
      r_data[r_wr] <= imem_data;
      r_ipc[r_wr]  <= r_addr;
    end

`ifdef FETCH_PERF_EN
  logic [CNT_W-1:0] r_stall;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_stall <= '0;
    else if (inst_ready && !inst_valid && !hlt && r_stall != '1) r_stall <= r_stall + CNT_W'(1);
  assign stall_cnt = r_stall;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random and directed stimulus against a queue-based model of the fetch stage,
// plus a second instance with RESET_PC=0xFFFE for wrap-around and stall saturation.
module tb_fetch_unit;
  typedef struct packed {logic [15:0] d; logic [15:0] a;} ent_t;

  logic        clk = 0, rst_n = 0, hlt = 0, redirect = 0, imem_ack = 0, inst_ready = 0;
  logic [15:0] redirect_pc = '0, imem_data = '0;
  logic        imem_req, inst_valid;
  logic [15:0] imem_addr, inst_data, inst_pc, pc;
  logic        w_req, w_valid, w_ack, w_ack_en = 0;
  logic [15:0] w_addr, w_idata, w_ipc, w_pc;
`ifdef FETCH_PERF_EN
  logic [15:0] stall_cnt;
  logic [3:0]  w_stall;
`endif

  ent_t        q[$];
  logic [15:0] m_pc, m_addr, m_stall, ea;
  bit          m_out, m_drop, busy, found;
  int          minlat, maxlat, lat, waited, n_vec = 0, n_err = 0;
  logic [31:0] r;

  always #5 clk = ~clk;
  assign w_ack = w_req & w_ack_en;

  fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n), .hlt(hlt), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready),
`ifdef FETCH_PERF_EN
    .stall_cnt(stall_cnt),
`endif
    .pc(pc));

  fetch_unit #(.RESET_PC(16'hFFFE)
`ifdef FETCH_PERF_EN
    , .CNT_W(4)
`endif
  ) u_wrap (
    .clk(clk), .rst_n(rst_n), .hlt(1'b0), .redirect(1'b0), .redirect_pc(16'h0000),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_data(16'h1234),
    .inst_valid(w_valid), .inst_data(w_idata), .inst_pc(w_ipc), .inst_ready(1'b1),
`ifdef FETCH_PERF_EN
    .stall_cnt(w_stall),
`endif
    .pc(w_pc));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc = 16'h0000; m_addr = 16'h0000; m_out = 0; m_drop = 0; m_stall = 0;
  endtask

  // One clock edge of the fetch stage, from the inputs held during the preceding cycle.
  task automatic model_step();
    bit pop, acked, push, issue;
    pop   = q.size() != 0 && inst_ready && !redirect;
    acked = m_out && imem_ack;
    push  = acked && !m_drop && !redirect;
    if (inst_ready && q.size() == 0 && !hlt && m_stall != 16'hFFFF) m_stall++;
    if (redirect) begin q.delete(); m_pc = redirect_pc; end
    if (pop) void'(q.pop_front());
    issue = !redirect && !hlt && (!m_out || push);
    if (push) begin q.push_back('{imem_data, m_addr}); m_pc = m_pc + 16'd2; end
    issue = issue && q.size() < 4;
    if (redirect && m_out && !imem_ack) m_drop = 1;
    if (acked) begin m_out = 0; m_drop = 0; end
    if (issue) begin m_out = 1; m_addr = m_pc; end
  endtask

  task automatic drive_mem();
    if (imem_req) begin
      if (!busy) begin busy = 1; waited = 0; lat = $urandom_range(maxlat, minlat); end
      imem_ack = (waited == lat);
      r = $urandom; imem_data = r[15:0];
      if (imem_ack) busy = 0; else waited++;
    end else begin
      imem_ack = 0; busy = 0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    #2;
    drive_mem();
  endtask

  task automatic do_reset();
    rst_n = 0; hlt = 0; redirect = 0; imem_ack = 0; busy = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
  endtask

  always @(negedge clk) if (rst_n) begin
    chk("req", imem_req, m_out);
    if (m_out) chk("addr", imem_addr, m_addr);
    chk("valid", inst_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("idata", inst_data, q[0].d);
      chk("ipc", inst_pc, q[0].a);
    end
    chk("pc", pc, m_pc);
`ifdef FETCH_PERF_EN
    chk("stall", stall_cnt, m_stall);
`endif
  end

  initial begin
    // Streaming with same-cycle ack; wrap instance starts at 0xFFFE.
    minlat = 0; maxlat = 0; inst_ready = 1; w_ack_en = 1;
    do_reset();
    cyc();
    chk("p1_req0", imem_req, 1); chk("p1_addr0", imem_addr, 16'h0000); chk("p1_valid0", inst_valid, 0);
    chk("w_addr0", w_addr, 16'hFFFE);
    cyc();
    chk("p1_valid1", inst_valid, 1); chk("p1_ipc0", inst_pc, 16'h0000); chk("p1_addr1", imem_addr, 16'h0002);
    chk("w_addr1", w_addr, 16'h0000); chk("w_ipc0", w_ipc, 16'hFFFE);
    cyc();
    chk("p1_ipc1", inst_pc, 16'h0002); chk("w_ipc1", w_ipc, 16'h0000);
    repeat (5) cyc();
    chk("p1_ipc6", inst_pc, 16'h000C);
    w_ack_en = 0;
    repeat (20) cyc();
`ifdef FETCH_PERF_EN
    chk("w_stall_sat", w_stall, 4'hF);
`endif
    // Fill with decode stalled, then drain.
    inst_ready = 0;
    do_reset();
    repeat (8) cyc();
    chk("p2_req", imem_req, 0); chk("p2_pc", pc, 16'h0008); chk("p2_ipc", inst_pc, 16'h0000);
    inst_ready = 1;
    cyc();
    chk("p2_pop", inst_pc, 16'h0002); chk("p2_resume", imem_req, 1); chk("p2_raddr", imem_addr, 16'h0008);
    // Redirect while 0x0006 is outstanding.
    minlat = 2; maxlat = 2;
    do_reset();
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin cyc(); found = imem_req && imem_addr == 16'h0006; end
    chk("p3_reach6", found, 1);
    redirect = 1; redirect_pc = 16'h0100;
    cyc();
    redirect = 0;
    chk("p3_flush", inst_valid, 0); chk("p3_pc", pc, 16'h0100);
    chk("p3_drop_req", imem_req, 1); chk("p3_drop_addr", imem_addr, 16'h0006);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin cyc(); found = inst_valid; end
    chk("p3_valid", found, 1); chk("p3_first", inst_pc, 16'h0100);
    // Halt with a request outstanding, drain, resume.
    do_reset();
    repeat (6) cyc();
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin found = imem_req; if (!found) cyc(); end
    chk("p4_outstanding", found, 1);
    ea = m_addr + 16'd2; hlt = 1;
    repeat (10) cyc();
    chk("p4_req", imem_req, 0); chk("p4_drained", inst_valid, 0); chk("p4_pc", pc, ea);
    hlt = 0;
    cyc();
    chk("p4_resume", imem_req, 1); chk("p4_addr", imem_addr, ea);
    // Asynchronous reset while a request is pending.
    inst_ready = 0; minlat = 0; maxlat = 1;
    do_reset();
    repeat (4) cyc();
    minlat = 3; maxlat = 3;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin cyc(); found = imem_req && !imem_ack; end
    chk("p5_pending", found, 1);
    #1 rst_n = 0; model_reset();
    #1;
    chk("p5_req", imem_req, 0); chk("p5_valid", inst_valid, 0); chk("p5_pc", pc, 16'h0000);
    // Random traffic.
    minlat = 0; maxlat = 3;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      cyc();
      r = $urandom;
      inst_ready = r[1:0] != 2'b00;
      hlt = r[6:3] == 4'h0;
      redirect = r[11:8] == 4'h0;
      redirect_pc = r[31:16] & 16'hFFFE;
    end
    redirect = 0; hlt = 0;
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
